// File: rtl/oric_pkg.sv
// Shared definitions for the Oric RAM arbiter: FSM state encoding and
// the default RAM address width.
package oric_pkg;

    localparam int ORIC_ADDR_W = 16;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } oric_state_e;

    // Word count for a given address width, used by sweep bookkeeping.
    function automatic int unsigned oric_ram_words(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/oric_clear_seq.sv
// Clear-sweep address sequencer. Walks 0 .. 2^ADDR_W-1 once per sweep.
// The extra counter MSB marks a finished sweep so the count never wraps
// into a second pass.
module oric_clear_seq #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_sys,
    input  logic              RESET,
    input  logic              in_clear,
    input  logic              clear_req,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              sweep_last
);

    logic [ADDR_W:0] clr_cnt_r;
    logic [ADDR_W:0] clr_cnt_next_s;

    assign clr_cnt_next_s = clr_cnt_r + {{ADDR_W{1'b0}}, 1'b1};

    // A restart request during a sweep writes address 0 this very cycle.
    assign clr_addr   = clear_req ? {ADDR_W{1'b0}} : clr_cnt_r[ADDR_W-1:0];

    // Last write of the sweep: the increment reaches 2^ADDR_W, unless a
    // restart is pending, which must never end the sweep early.
    assign sweep_last = in_clear & ~clear_req & clr_cnt_next_s[ADDR_W];

    // Sweep counter: restart, advance while clearing, park at completion.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            clr_cnt_r <= {(ADDR_W+1){1'b0}};
        end else if (in_clear) begin
            if (clear_req) begin
                clr_cnt_r <= {{ADDR_W{1'b0}}, 1'b1};
            end else if (!clr_cnt_r[ADDR_W]) begin
                clr_cnt_r <= clr_cnt_next_s;
            end else begin
                clr_cnt_r <= clr_cnt_r;
            end
        end else if (clear_req) begin
            clr_cnt_r <= {(ADDR_W+1){1'b0}};
        end else begin
            clr_cnt_r <= clr_cnt_r;
        end
    end

endmodule

// File: rtl/oric_ram_arbiter.sv
// Oric RAM port arbiter. After reset (or on request) the whole RAM is
// swept with CLEAR_DATA while the CPU is held; afterwards the CPU owns
// the RAM slot whenever cpu_act is high and the loader fills the gaps.
// All RAM-side outputs are registered: one cycle after selection.
module oric_ram_arbiter
    import oric_pkg::*;
#(
    parameter int         ADDR_W     = ORIC_ADDR_W,
    parameter logic [7:0] CLEAR_DATA = 8'h00
) (
    input  logic              clk_sys,
    input  logic              RESET,
    input  logic              clear_req,
    input  logic [ADDR_W-1:0] cpu_ad,
    input  logic [7:0]        cpu_d,
    input  logic              cpu_we,
    input  logic              cpu_act,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [7:0]        ram_d,
    output logic              ram_we,
    output logic              cpu_hold,
    output logic              clear_done
);

    oric_state_e       state_r;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              sweep_last_s;
    logic              in_clear_s;

    assign in_clear_s = (state_r == ST_CLEAR);
    assign cpu_hold   = in_clear_s;
    // The loader only gets slots the CPU leaves free, and none while clearing.
    assign ld_ready   = (state_r == ST_RUN) & ~cpu_act;

    oric_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .in_clear   (in_clear_s),
        .clear_req  (clear_req),
        .clr_addr   (clr_addr_s),
        .sweep_last (sweep_last_s)
    );

    // Arbitration FSM with registered RAM port and done pulse.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_r    <= ST_CLEAR;
            ram_ad     <= {ADDR_W{1'b0}};
            ram_d      <= 8'h00;
            ram_we     <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    ram_ad <= clr_addr_s;
                    ram_d  <= CLEAR_DATA;
                    ram_we <= 1'b1;
                    if (sweep_last_s) begin
                        state_r    <= ST_RUN;
                        clear_done <= 1'b1;
                    end else begin
                        state_r    <= ST_CLEAR;
                        clear_done <= 1'b0;
                    end
                end
                ST_RUN: begin
                    clear_done <= 1'b0;
                    if (cpu_act) begin
                        ram_ad <= cpu_ad;
                        ram_d  <= cpu_d;
                        ram_we <= cpu_we;
                    end else if (ld_valid && ld_ready) begin
                        ram_ad <= ld_addr;
                        ram_d  <= ld_data;
                        ram_we <= 1'b1;
                    end else begin
                        ram_ad <= ram_ad;
                        ram_d  <= ram_d;
                        ram_we <= 1'b0;
                    end
                    if (clear_req) begin
                        state_r <= ST_CLEAR;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r    <= ST_CLEAR;
                    ram_ad     <= {ADDR_W{1'b0}};
                    ram_d      <= 8'h00;
                    ram_we     <= 1'b0;
                    clear_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oric_ram_arbiter.sv
// Directed bench for oric_ram_arbiter at ADDR_W=4. Expected RAM-port
// values are queued when inputs are driven and compared one cycle later.
// Addresses from the 16-bit scenarios are reduced to 4-bit values.
module tb_oric_ram_arbiter;

    localparam int         AW  = 4;
    localparam logic [7:0] CLR = 8'h5A;

    logic          clk_sys = 1'b0;
    logic          RESET;
    logic          clear_req;
    logic [AW-1:0] cpu_ad;
    logic [7:0]    cpu_d;
    logic          cpu_we;
    logic          cpu_act;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          ld_ready;
    logic [AW-1:0] ram_ad;
    logic [7:0]    ram_d;
    logic          ram_we;
    logic          cpu_hold;
    logic          clear_done;

    typedef struct {
        logic          we;
        logic [AW-1:0] ad;
        logic [7:0]    d;
        logic          done;
        logic          hold;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] mdl_ad;
    logic [7:0]    mdl_d;
    int            total  = 0;
    int            passed = 0;
    int            failed = 0;
    int            writes;
    int            dones;

    oric_ram_arbiter #(
        .ADDR_W     (AW),
        .CLEAR_DATA (CLR)
    ) dut (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .clear_req  (clear_req),
        .cpu_ad     (cpu_ad),
        .cpu_d      (cpu_d),
        .cpu_we     (cpu_we),
        .cpu_act    (cpu_act),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .ram_ad     (ram_ad),
        .ram_d      (ram_d),
        .ram_we     (ram_we),
        .cpu_hold   (cpu_hold),
        .clear_done (clear_done)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic we, input logic [AW-1:0] ad, input logic [7:0] d,
                        input logic done, input logic hold);
        exp_t e;
        e.we = we; e.ad = ad; e.d = d; e.done = done; e.hold = hold;
        exp_q.push_back(e);
        mdl_ad = ad;
        mdl_d  = d;
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk_sys);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            failed++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            chk("ram_we",     {31'd0, ram_we},     {31'd0, e.we});
            chk("ram_ad",     {28'd0, ram_ad},     {28'd0, e.ad});
            chk("ram_d",      {24'd0, ram_d},      {24'd0, e.d});
            chk("clear_done", {31'd0, clear_done}, {31'd0, e.done});
            chk("cpu_hold",   {31'd0, cpu_hold},   {31'd0, e.hold});
        end
    endtask

    initial begin
        RESET = 1'b1; clear_req = 1'b0;
        cpu_ad = 4'h0; cpu_d = 8'h00; cpu_we = 1'b0; cpu_act = 1'b0;
        ld_valid = 1'b0; ld_addr = 4'h0; ld_data = 8'h00;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_ram_we",     {31'd0, ram_we},     32'd0);
        chk("rst_ram_ad",     {28'd0, ram_ad},     32'd0);
        chk("rst_ram_d",      {24'd0, ram_d},      32'd0);
        chk("rst_clear_done", {31'd0, clear_done}, 32'd0);
        chk("rst_cpu_hold",   {31'd0, cpu_hold},   32'd1);
        chk("rst_ld_ready",   {31'd0, ld_ready},   32'd0);
        mdl_ad = 4'h0; mdl_d = 8'h00;

        // Power-on sweep with a loader request pending the whole time.
        RESET = 1'b0; ld_valid = 1'b1; ld_addr = 4'h3; ld_data = 8'hEE;
        for (int i = 0; i < 16; i++) begin
            chk("ld_ready_in_clear", {31'd0, ld_ready}, 32'd0);
            push(1'b1, 4'(i), CLR, i == 15, i != 15);
            step();
        end
        ld_valid = 1'b0;
        push(1'b0, mdl_ad, mdl_d, 1'b0, 1'b0);
        step();

        // CPU beats the loader.
        cpu_act = 1'b1; cpu_ad = 4'h4; cpu_d = 8'h33; cpu_we = 1'b1;
        ld_valid = 1'b1; ld_addr = 4'h5; ld_data = 8'hA5;
        #1;
        chk("ld_ready_cpu_act", {31'd0, ld_ready}, 32'd0);
        push(1'b1, 4'h4, 8'h33, 1'b0, 1'b0);
        step();

        // Loader transfers in free slots, including the top address.
        cpu_act = 1'b0;
        #1;
        chk("ld_ready_free", {31'd0, ld_ready}, 32'd1);
        push(1'b1, 4'h5, 8'hA5, 1'b0, 1'b0);
        step();
        ld_addr = 4'hF; ld_data = 8'hFF;
        push(1'b1, 4'hF, 8'hFF, 1'b0, 1'b0);
        step();

        // CPU read cycle: address and data registered, no write.
        ld_valid = 1'b0; cpu_act = 1'b1; cpu_we = 1'b0; cpu_ad = 4'h7; cpu_d = 8'h11;
        push(1'b0, 4'h7, 8'h11, 1'b0, 1'b0);
        step();

        // Idle: nothing writes, address holds.
        cpu_act = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push(1'b0, mdl_ad, mdl_d, 1'b0, 1'b0);
            step();
        end

        // Clear request from RUN, then a restart at sweep address 8.
        clear_req = 1'b1;
        push(1'b0, mdl_ad, mdl_d, 1'b0, 1'b1);
        step();
        writes = 0; dones = 0;
        for (int k = 0; k < 24; k++) begin
            clear_req = (k == 8);
            push(1'b1, (k < 8) ? 4'(k) : 4'(k - 8), CLR, k == 23, k != 23);
            step();
            if (ram_we) writes++;
            if (clear_done) dones++;
        end
        clear_req = 1'b0;
        push(1'b0, mdl_ad, mdl_d, 1'b0, 1'b0);
        step();
        if (clear_done) dones++;
        chk("restart_writes", writes, 32'd24);
        chk("restart_dones",  dones,  32'd1);

        // Reset in the middle of a sweep at address 5.
        clear_req = 1'b1;
        push(1'b0, mdl_ad, mdl_d, 1'b0, 1'b1);
        step();
        clear_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push(1'b1, 4'(k), CLR, 1'b0, 1'b1);
            step();
        end
        RESET = 1'b1;
        push(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        step();
        RESET = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push(1'b1, 4'(i), CLR, i == 15, i != 15);
            step();
        end

        // Reset during RUN restarts a full sweep.
        cpu_act = 1'b1; cpu_we = 1'b1; cpu_ad = 4'h9; cpu_d = 8'h77;
        push(1'b1, 4'h9, 8'h77, 1'b0, 1'b0);
        step();
        cpu_act = 1'b0; cpu_we = 1'b0;
        RESET = 1'b1;
        push(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        step();
        RESET = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push(1'b1, 4'(i), CLR, i == 15, i != 15);
            step();
        end
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/oric_ram_arbiter.md
ORIC_RAM_ARBITER -- requirements
Module: oric_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, RAM address width in bits.
REQ-002 Parameter CLEAR_DATA, default 8'h00, byte written to every location during a clear sweep.
REQ-003 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 RESET  in  1  reset, synchronous, active-high.
REQ-005 clear_req  in  1  one-cycle pulse requesting a full RAM clear sweep.
REQ-006 cpu_ad  in  ADDR_W  CPU address.
REQ-007 cpu_d  in  8  CPU write data.
REQ-008 cpu_we  in  1  CPU write enable.
REQ-009 cpu_act  in  1  CPU owns the RAM slot this cycle.
REQ-010 ld_valid  in  1  loader write request valid.
REQ-011 ld_addr  in  ADDR_W  loader write address.
REQ-012 ld_data  in  8  loader write data.
REQ-013 ld_ready  out  1  loader write accepted this cycle.
REQ-014 ram_ad  out  ADDR_W  registered RAM address.
REQ-015 ram_d  out  8  registered RAM write data.
REQ-016 ram_we  out  1  registered RAM write enable.
REQ-017 cpu_hold  out  1  CPU must stall; high throughout a clear sweep.
REQ-018 clear_done  out  1  one-cycle pulse after the last clear write.

Function
REQ-019 The FSM SHALL have exactly two states: CLEAR and RUN.
REQ-020 In CLEAR, each cycle SHALL drive ram_ad=clr_cnt, ram_d=CLEAR_DATA and ram_we=1, then increment clr_cnt.
REQ-021 CLEAR SHALL last exactly 2^ADDR_W cycles (addresses 0 .. 2^ADDR_W-1 in order), then enter RUN.
REQ-022 clear_done SHALL pulse for the one cycle on which the FSM enters RUN.
REQ-023 clear_req in RUN SHALL enter CLEAR with clr_cnt=0 on the next cycle.
REQ-024 clear_req in CLEAR SHALL restart the sweep from address 0 and must not pulse clear_done early.
REQ-025 cpu_hold SHALL equal 1 in CLEAR and 0 in RUN.
REQ-026 ld_ready SHALL be combinational: 1 iff state==RUN and cpu_act==0.
REQ-027 A loader transfer occurs when ld_valid and ld_ready are both 1; ld_data and ld_addr SHALL then be written.
REQ-028 In RUN with cpu_act=1, the block SHALL register cpu_ad, cpu_d and cpu_we onto ram_*; the CPU always beats the loader.
REQ-029 In RUN on a loader transfer, the block SHALL register ld_addr, ld_data and 1 onto ram_ad, ram_d and ram_we.
REQ-030 In RUN with neither, ram_ad SHALL hold its value and ram_we SHALL be 0.
REQ-031 ram_* SHALL have exactly one cycle of latency from the selecting cycle.
REQ-032 clr_cnt SHALL be ADDR_W+1 bits wide; its MSB marks sweep completion, with no wrap into a second pass.
REQ-033 ld_valid in CLEAR SHALL be ignored (ld_ready=0), and the request is held by the loader.

Reset
REQ-034 RESET SHALL force state=CLEAR, clr_cnt=0, ram_ad=0, ram_d=0, ram_we=0 and clear_done=0.
REQ-035 After RESET, cpu_hold SHALL read 1 and a full sweep SHALL follow automatically.
REQ-036 RESET asserted mid-sweep or mid-RUN SHALL abort and restart the sweep from address 0.

Structure
REQ-037 A shared package oric_pkg SHALL hold the state enum (ST_CLEAR, ST_RUN) and the ADDR_W default constant.
REQ-038 The block SHALL be a single flat module; one optional sub-module oric_clear_seq (sweep counter plus done detect) is permitted.

Verification
REQ-039 Reset test, ADDR_W=4: after RESET, ram_we=1 for 16 cycles with ram_ad 0..15 and ram_d=CLEAR_DATA, then clear_done pulses once and cpu_hold=0.
REQ-040 Priority test: in RUN, cpu_act=1, cpu_ad=16'h1234, cpu_we=1, ld_valid=1 -> ld_ready=0, and next cycle ram_ad=16'h1234, ram_we=1.
REQ-041 Loader test: in RUN, cpu_act=0, ld_valid=1, ld_addr=16'h0500, ld_data=8'hA5 -> ld_ready=1, and next cycle ram_ad=16'h0500, ram_d=8'hA5, ram_we=1.
REQ-042 Restart test: clear_req at sweep address 8 (ADDR_W=4) -> next ram_ad=0, total 24 clear writes, exactly one clear_done.
REQ-043 Mid-sweep reset test: RESET during a sweep at address 5 -> ram_we=0 for that cycle, then a sweep from 0, and cpu_hold stays 1 throughout.
REQ-044 Idle test: in RUN, cpu_act=0, ld_valid=0 for 10 cycles -> ram_we=0 and ram_ad unchanged.
